pc_seq: RTL and testbench
=========================

# pc_seq

Parametrised program-counter sequencer for the multicycle core: it holds the PC, computes the next fetch address (increment, conditional relative branch, absolute jump, return), and keeps a small hardware link stack for call/return. It sits between the control FSM (which supplies the enable, source select and branch qualifier) and the instruction-memory address mux. It replaces the fixed 16-bit PC register plus external next-PC mux with one registered, width-generic block.

## Interface
- AW, 16, PC / address width
- DISP_W, 8, branch displacement width (two's complement, sign-extended to AW)
- STACK_DEPTH, 4, link-stack entries (power of two, ≥2)
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous active-low reset (0 = reset)
- pc_en  input  1  advance PC this cycle (from FSM)
- pc_src  input  2  00 inc, 01 branch rel, 10 jump abs, 11 return
- cond_ok  input  1  branch condition met (evaluated by FSM from flags)
- disp  input  DISP_W  signed branch displacement
- jump_addr  input  AW  absolute target (register value)
- link  input  1  with pc_src=10: push PC+1 as return address
- err_clr  input  1  clears sticky error flags
- pc  output  AW  current PC (registered)
- pc_next  output  AW  combinational next PC
- taken  output  1  registered 1-cycle pulse: last update was a redirect
- stack_empty  output  1  link stack empty
- stack_full  output  1  link stack full
- ovf  output  1  sticky: push while full
- unf  output  1  sticky: return while empty

## Operation
- pc_en=0: pc, stack, taken (→0) hold/clear as stated; pc_next still computed.
- pc_en=1, pc_src selects:
  - 00: pc ← pc+1.
  - 01: cond_ok=1 → pc ← pc+sext(disp), taken=1; else pc ← pc+1, taken=0.
  - 10: pc ← jump_addr, taken=1; link=1 → push pc+1.
  - 11: stack non-empty → pop, pc ← popped value, taken=1; empty → pc ← pc+1, unf ← 1, taken=0.
- All PC arithmetic modulo 2^AW (0xFFFF+1 → 0x0000 at AW=16; negative disp wraps below 0).
- Link stack: circular LIFO with count 0..STACK_DEPTH. Push while full overwrites the oldest entry, count stays STACK_DEPTH, ovf ← 1.
- link ignored unless pc_src=10.
- err_clr=1 clears ovf/unf that cycle; a new error in the same cycle wins (flag set).
- Reset (async, rst=0): pc=RESET_PC, count=0, stack_empty=1, stack_full=0, taken=0, ovf=0, unf=0; stack contents don't-care. Reset mid-call discards all return addresses.

## Timing
- Single-cycle update: inputs sampled on the rising edge with pc_en=1; new pc visible after that edge.
- pc_next is combinational from pc, pc_src, cond_ok, disp, jump_addr and stack top; the address mux may use it for zero-wait fetch.
- taken asserted the cycle after the redirecting edge, for exactly one cycle.
- stack_empty/stack_full reflect the registered count; they update on the same edge as the push/pop.
- No internal latency beyond one register stage; back-to-back updates on consecutive cycles are legal.

## Structure
- Shared package: pc_src encodings (PC_INC, PC_BR, PC_JMP, PC_RET) shared with the control FSM; displacement sign-extension helper.
- Sub-module link_stack (parameters AW, STACK_DEPTH): push/pop/data/full/empty/overflow; pc_seq owns the PC register, next-PC mux, taken and sticky flags.

## Test plan
- Reset release with RESET_PC=0x0010, pc_src=00, pc_en=1 for 3 cycles → pc 0x0010,0x0011,0x0012,0x0013; taken=0 throughout.
- pc=0x0020, pc_src=01, disp=0xFC, cond_ok=1 → pc=0x001C, taken pulses; same with cond_ok=0 → pc=0x0021, taken=0.
- pc=0xFFFF, pc_src=00 → pc=0x0000; pc=0x0002, disp=0x80 (-128), taken → pc=0xFF82.
- Call/return: pc=0x0100, pc_src=10, link=1, jump_addr=0x0400 → pc=0x0400, stack_empty=0; later pc_src=11 → pc=0x0101, stack_empty=1.
- Overflow: 5 linked jumps with STACK_DEPTH=4 → ovf=1, stack_full=1; 4 returns yield 5th..2nd return addresses; 5th return → pc+1, unf=1; err_clr → ovf=unf=0.
- pc_en=0 with pc_src=10, link=1 → pc and stack unchanged; assert rst=0 mid-stream (async, between edges) → pc=RESET_PC and flags cleared immediately.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared next-PC source encodings and displacement helper
package pc_seq_pkg;

  // Next-PC source select, shared with the control FSM
  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_RET = 2'b11
  } pc_src_e;

  // Widest address/displacement the helper can carry
  localparam int SEXT_MAX_W = 64;

  // Sign-extend the low 'w' bits of 'd' to SEXT_MAX_W bits.
  // Callers cast the result down to their own address width.
  function automatic logic [SEXT_MAX_W-1:0] sext_disp(
    input logic [SEXT_MAX_W-1:0] d,
    input int                    w
  );
    logic [SEXT_MAX_W-1:0] r;
    r = d;
    for (int i = 0; i < SEXT_MAX_W; i++) begin
      if (i >= w) r[i] = d[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_seq_link_stack.sv
// rtl/pc_seq_link_stack.sv - circular LIFO of return addresses for call/return
module link_stack
  import pc_seq_pkg::*;
#(
  parameter int AW          = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  // Depth is a power of two, so the write pointer wraps for free and a push
  // while full lands exactly on the oldest entry.
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(STACK_DEPTH);

  logic [AW-1:0]    mem [STACK_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W:0]   count;

  // Top of stack is the slot just below the next write position
  always_comb begin
    top_ptr  = wr_ptr - 1'b1;
    top_data = mem[top_ptr];
    full     = (count == DEPTH_C);
    empty    = (count == '0);
    overflow = push && full;
  end

  // Pointer and occupancy; push wins if both are ever requested together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end
  end

  // Entry storage; contents after reset are irrelevant since count is zero
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program-counter register, next-PC mux, link stack and error flags
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int            AW          = 16,
  parameter int            DISP_W      = 8,
  parameter int            STACK_DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic [1:0]        pc_src,
  input  logic              cond_ok,
  input  logic [DISP_W-1:0] disp,
  input  logic [AW-1:0]     jump_addr,
  input  logic              link,
  input  logic              err_clr,
  output logic [AW-1:0]     pc,
  output logic [AW-1:0]     pc_next,
  output logic              taken,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              ovf,
  output logic              unf
);

  pc_src_e       src;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] disp_ext;
  logic [AW-1:0] stack_top;
  logic          redirect;
  logic          push;
  logic          pop;
  logic          unf_evt;
  logic          ovf_evt;

  assign src      = pc_src_e'(pc_src);
  assign pc_inc   = pc + 1'b1;
  assign disp_ext = AW'(sext_disp(SEXT_MAX_W'(disp), DISP_W));

  // Next-PC mux; evaluated every cycle so the fetch mux can use it even
  // when the PC is not advancing. Redirect marks a non-sequential target.
  always_comb begin
    pc_next  = pc_inc;
    redirect = 1'b0;
    unf_evt  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    case (src)
      PC_INC: begin
        pc_next = pc_inc;
      end
      PC_BR: begin
        if (cond_ok) begin
          pc_next  = pc + disp_ext;
          redirect = 1'b1;
        end
      end
      PC_JMP: begin
        pc_next  = jump_addr;
        redirect = 1'b1;
        push     = pc_en && link;
      end
      PC_RET: begin
        if (!stack_empty) begin
          pc_next  = stack_top;
          redirect = 1'b1;
          pop      = pc_en;
        end else begin
          unf_evt  = pc_en;
        end
      end
      default: begin
        pc_next = pc_inc;
      end
    endcase
  end

  link_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_link_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (stack_top),
    .full      (stack_full),
    .empty     (stack_empty),
    .overflow  (ovf_evt)
  );

  // PC register and one-cycle redirect pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC;
      taken <= 1'b0;
    end else begin
      taken <= pc_en && redirect;
      if (pc_en) pc <= pc_next;
    end
  end

  // Sticky stack error flags; a fresh error beats a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_evt)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (unf_evt)      unf <= 1'b1;
      else if (err_clr) unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - self-checking bench for pc_seq against a queue-based model
module tb_pc_seq;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int SD   = 4;
  localparam int RPC  = 'h0010;
  localparam int MASK = 'hFFFF;

  logic          clk;
  logic          rst;
  logic          pc_en;
  logic [1:0]    pc_src;
  logic          cond_ok;
  logic [DW-1:0] disp;
  logic [AW-1:0] jump_addr;
  logic          link;
  logic          err_clr;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic          taken;
  logic          stack_empty;
  logic          stack_full;
  logic          ovf;
  logic          unf;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  bit m_taken, m_ovf, m_unf;

  pc_seq #(
    .AW(AW), .DISP_W(DW), .STACK_DEPTH(SD), .RESET_PC(16'h0010)
  ) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .pc_src(pc_src), .cond_ok(cond_ok),
    .disp(disp), .jump_addr(jump_addr), .link(link), .err_clr(err_clr),
    .pc(pc), .pc_next(pc_next), .taken(taken), .stack_empty(stack_empty),
    .stack_full(stack_full), .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sdisp(input logic [DW-1:0] d);
    return (int'(d) >= 128) ? int'(d) - 256 : int'(d);
  endfunction

  function automatic int model_next(input logic [1:0] s, input logic c,
                                    input logic [DW-1:0] d, input logic [AW-1:0] ja);
    case (s)
      2'd1:    return c ? ((m_pc + sdisp(d)) & MASK) : ((m_pc + 1) & MASK);
      2'd2:    return int'(ja);
      2'd3:    return (m_stk.size() > 0) ? m_stk[$] : ((m_pc + 1) & MASK);
      default: return (m_pc + 1) & MASK;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RPC;
    m_stk.delete();
    m_taken = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc"},    32'(pc),          32'(m_pc));
    check({tag, ".taken"}, 32'(taken),       32'(m_taken));
    check({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
    check({tag, ".full"},  32'(stack_full),  32'(m_stk.size() == SD));
    check({tag, ".ovf"},   32'(ovf),         32'(m_ovf));
    check({tag, ".unf"},   32'(unf),         32'(m_unf));
  endtask

  // One cycle: drive at the falling edge, check pc_next, clock, check state
  task automatic step(input string tag, input logic en, input logic [1:0] s,
                      input logic c, input logic [DW-1:0] d,
                      input logic [AW-1:0] ja, input logic lk, input logic clr);
    int  nxt;
    bit  oe, ue, red;
    pc_en = en; pc_src = s; cond_ok = c; disp = d; jump_addr = ja;
    link = lk; err_clr = clr;
    nxt = model_next(s, c, d, ja);
    #1;
    check({tag, ".pc_next"}, 32'(pc_next), 32'(nxt));
    oe = 0; ue = 0;
    red = (s == 2'd2) || (s == 2'd1 && c) || (s == 2'd3 && m_stk.size() > 0);
    if (en) begin
      if (s == 2'd2 && lk) begin
        if (m_stk.size() == SD) begin
          oe = 1;
          void'(m_stk.pop_front());
        end
        m_stk.push_back((m_pc + 1) & MASK);
      end else if (s == 2'd3) begin
        if (m_stk.size() > 0) void'(m_stk.pop_back());
        else ue = 1;
      end
      m_pc = nxt;
    end
    m_taken = en && red;
    m_ovf = oe ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = ue ? 1'b1 : (clr ? 1'b0 : m_unf);
    @(posedge clk);
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    rst = 1'b0; pc_en = 0; pc_src = 0; cond_ok = 0; disp = 0;
    jump_addr = 0; link = 0; err_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b1;

    // Sequential fetch from RESET_PC
    step("inc0", 1, 2'd0, 0, 8'h00, 16'h0, 0, 0);
    step("inc1", 1, 2'd0, 0, 8'h00, 16'h0, 0, 0);
    step("inc2", 1, 2'd0, 0, 8'h00, 16'h0, 0, 0);
    check("inc_pc13", 32'(pc), 32'h0013);

    // Relative branch taken / not taken
    step("set20",  1, 2'd2, 0, 8'h00, 16'h0020, 0, 0);
    step("br_tk",  1, 2'd1, 1, 8'hFC, 16'h0, 0, 0);
    check("br_tk_pc", 32'(pc), 32'h001C);
    check("br_tk_taken", 32'(taken), 32'h1);
    step("set20b", 1, 2'd2, 0, 8'h00, 16'h0020, 0, 0);
    step("br_nt",  1, 2'd1, 0, 8'hFC, 16'h0, 0, 0);
    check("br_nt_pc", 32'(pc), 32'h0021);
    check("br_nt_taken", 32'(taken), 32'h0);

    // Wraparound
    step("setFFFF", 1, 2'd2, 0, 8'h00, 16'hFFFF, 0, 0);
    step("wrap",    1, 2'd0, 0, 8'h00, 16'h0, 0, 0);
    check("wrap_pc", 32'(pc), 32'h0000);
    step("set2",    1, 2'd2, 0, 8'h00, 16'h0002, 0, 0);
    step("br_neg",  1, 2'd1, 1, 8'h80, 16'h0, 0, 0);
    check("br_neg_pc", 32'(pc), 32'hFF82);

    // Call / return
    step("set100", 1, 2'd2, 0, 8'h00, 16'h0100, 0, 0);
    step("call",   1, 2'd2, 0, 8'h00, 16'h0400, 1, 0);
    check("call_pc", 32'(pc), 32'h0400);
    step("ret",    1, 2'd3, 0, 8'h00, 16'h0, 0, 0);
    check("ret_pc", 32'(pc), 32'h0101);
    check("ret_empty", 32'(stack_empty), 32'h1);

    // Overflow, drain, underflow, clear
    for (int i = 1; i <= 5; i++)
      step("ocall", 1, 2'd2, 0, 8'h00, 16'(i * 'h1000), 1, 0);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_full", 32'(stack_full), 32'h1);
    for (int i = 4; i >= 1; i--) begin
      step("oret", 1, 2'd3, 0, 8'h00, 16'h0, 0, 0);
      check("oret_pc", 32'(pc), 32'(i * 'h1000 + 1));
    end
    step("uret", 1, 2'd3, 0, 8'h00, 16'h0, 0, 0);
    check("uret_pc", 32'(pc), 32'h1002);
    check("unf_set", 32'(unf), 32'h1);
    step("clr", 0, 2'd0, 0, 8'h00, 16'h0, 0, 1);
    check("clr_ovf", 32'(ovf), 32'h0);
    check("clr_unf", 32'(unf), 32'h0);

    // Hold: linked jump with pc_en low
    step("hold", 0, 2'd2, 0, 8'h00, 16'h0777, 1, 0);
    check("hold_pc", 32'(pc), 32'h1002);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd", ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom), 8'($urandom), 16'($urandom), 1'($urandom),
           ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset between edges
    step("pre_rst", 1, 2'd2, 0, 8'h00, 16'h0ABC, 1, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step("post_rst", 1, 2'd3, 0, 8'h00, 16'h0, 0, 0);
    check("post_rst_unf", 32'(unf), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
